// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, status-window
// offsets and the fault_stat layout.
package dmem_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    MOP_W   = 2'b00,
    MOP_H   = 2'b01,
    MOP_B   = 2'b10,
    MOP_RSV = 2'b11
  } mop_e;

  localparam logic [3:0] OFF_LCNT  = 4'h0;
  localparam logic [3:0] OFF_SCNT  = 4'h4;
  localparam logic [3:0] OFF_FADDR = 4'h8;
  localparam logic [3:0] OFF_FSTAT = 4'hC;

  localparam int FS_FAULT = 0;
  localparam int FS_OP_LO = 1;
  localparam int FS_STORE = 3;
  localparam int FS_OOR   = 4;
  localparam int FS_W     = 5;

  // Packed so that field order lands on the FS_* bit positions above.
  typedef struct packed {
    logic       oor;
    logic       store;
    logic [1:0] op;
    logic       fault;
  } fstat_t;

  function automatic logic is_aligned(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      MOP_W:   return lo == 2'b00;
      MOP_H:   return !lo[0];
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/dmem_if.sv
// CPU data-port bundle: the CPU drives address/data/controls, the responder
// returns load data, the sticky fault flag and the debug word.
interface dmem_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          mem_we;
  logic          mem_re;
  logic [1:0]    mem_op;
  logic          ext_op;
  logic [31:0]   rdata;
  logic          fault;
  logic [IW-1:0] dbg_sel;
  logic [31:0]   dbg_data;

  modport master (
    output addr, wdata, mem_we, mem_re, mem_op, ext_op, dbg_sel,
    input  rdata, fault, dbg_data
  );

  modport slave (
    input  addr, wdata, mem_we, mem_re, mem_op, ext_op, dbg_sel,
    output rdata, fault, dbg_data
  );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane steering: alignment check, load lane select with
// sign/zero extension, and store byte enables with lane-replicated data.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]                           mem_op,
  input  logic [1:0]                           lane,
  input  logic                                 ext_op,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]     rword,
  input  logic [31:0]                          wdata,
  output logic                                 aligned,
  output logic [31:0]                          ldata,
  output logic [NUM_LANES-1:0]                 be,
  output logic [NUM_LANES-1:0][LANE_W-1:0]     wlane
);
  logic [15:0]       half;
  logic [LANE_W-1:0] byte_v;

  assign aligned = is_aligned(mem_op, lane);
  assign half    = lane[1] ? rword[3:2] : rword[1:0];
  assign byte_v  = rword[lane];

  // Store data is replicated across lanes; be picks which lanes are written.
  always_comb begin
    ldata = '0;
    be    = '0;
    wlane = wdata;
    case (mem_op)
      MOP_W: begin
        ldata = rword;
        be    = '1;
      end
      MOP_H: begin
        ldata = {{16{ext_op & half[15]}}, half};
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      MOP_B: begin
        ldata = {{24{ext_op & byte_v[7]}}, byte_v};
        be    = 4'b0001 << lane;
        wlane = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane RAM with combinational loads, region
// decode, load/store counters and a first-fault-wins status window.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int          IW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic                             in_ram, in_mmio, oor;
  logic                             active, is_st, is_ld;
  logic                             aligned, err, ok;
  logic                             st_ram_we;
  logic [3:0]                       off;
  logic [IW-1:0]                    widx;
  logic [31:0]                      ldata, mmio_rd;
  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] wlane, rword, dword;

  logic [31:0] load_cnt, store_cnt, fault_addr;
  fstat_t      fstat;

  assign in_ram  = bus.addr < RAM_BYTES;
  assign in_mmio = (bus.addr >= MMIO_BASE) && (bus.addr < MMIO_BASE + 32'd16);
  assign oor     = !in_ram && !in_mmio;
  assign off     = bus.addr[3:0] - MMIO_BASE[3:0];
  assign widx    = bus.addr[IW+1:2];

  // A store wins when both strobes are high.
  assign active = bus.mem_we | bus.mem_re;
  assign is_st  = bus.mem_we;
  assign is_ld  = bus.mem_re & ~bus.mem_we;

  assign err = active && (!aligned || bus.mem_op == MOP_RSV || oor ||
                          (in_mmio && bus.mem_op != MOP_W));
  assign ok  = active && !err;

  dmem_align u_align (
    .mem_op  (bus.mem_op),
    .lane    (bus.addr[1:0]),
    .ext_op  (bus.ext_op),
    .rword   (rword),
    .wdata   (bus.wdata),
    .aligned (aligned),
    .ldata   (ldata),
    .be      (be),
    .wlane   (wlane)
  );

  // Reset blocks the write so a store landing on a reset edge is dropped.
  assign st_ram_we = ok && is_st && in_ram && !rst;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk)
      if (st_ram_we && be[l]) mem[widx] <= wlane[l];

    assign rword[l] = mem[widx];
    assign dword[l] = mem[bus.dbg_sel];
  end

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_LCNT:  mmio_rd = load_cnt;
      OFF_SCNT:  mmio_rd = store_cnt;
      OFF_FADDR: mmio_rd = fault_addr;
      OFF_FSTAT: mmio_rd = {{(32-FS_W){1'b0}}, fstat};
      default:   mmio_rd = '0;
    endcase
  end

  assign bus.rdata    = (is_ld && ok) ? (in_ram ? ldata : mmio_rd) : '0;
  assign bus.dbg_data = dword;
  assign bus.fault    = fstat.fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt   <= '0;
      store_cnt  <= '0;
      fault_addr <= '0;
      fstat      <= '0;
    end else begin
      if (ok && in_ram) begin
        if (is_st) store_cnt <= store_cnt + 32'd1;
        else       load_cnt  <= load_cnt + 32'd1;
      end
      if (err && !fstat.fault) begin
        fstat      <= '{oor: oor, store: is_st, op: bus.mem_op, fault: 1'b1};
        fault_addr <= bus.addr;
      end else if (ok && is_st && in_mmio && off == OFF_FSTAT && bus.wdata[FS_FAULT]) begin
        fstat      <= '0;
        fault_addr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench: byte-level reference model compared every cycle, plus
// directed literal checks and a randomized access phase.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int          DW     = 1024;
  localparam logic [31:0] MB     = 32'h0000_7F00;
  localparam int          INIT_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.DEPTH_WORDS(DW)) bus ();

  dmem_resp #(.DEPTH_WORDS(DW), .MMIO_BASE(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [7:0]  m_mem [DW*4];
  logic [31:0] m_lcnt, m_scnt, m_faddr;
  logic [4:0]  m_fstat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bit m_ram(input logic [31:0] a);
    return a < 32'(DW * 4);
  endfunction

  function automatic bit m_mmio(input logic [31:0] a);
    return (a >= MB) && (a < MB + 32'd16);
  endfunction

  function automatic int m_size(input logic [1:0] op);
    return (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 0;
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic we, input logic re,
                               input logic [1:0] op);
    if (!(we || re)) return 1'b0;
    if (op == 2'd3) return 1'b1;
    if ((a % 32'(m_size(op))) != 0) return 1'b1;
    if (!m_ram(a) && !m_mmio(a)) return 1'b1;
    if (m_mmio(a) && op != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic we, input logic re,
                                         input logic [1:0] op, input logic ext);
    logic [31:0] v;
    int n;
    v = '0;
    if (!re || we || m_err(a, we, re, op)) return '0;
    if (m_mmio(a)) begin
      case (a - MB)
        32'd0:   return m_lcnt;
        32'd4:   return m_scnt;
        32'd8:   return m_faddr;
        32'd12:  return {27'b0, m_fstat};
        default: return '0;
      endcase
    end
    n = m_size(op);
    for (int i = 0; i < n; i++) v = v | (32'(m_mem[a + 32'(i)]) << (8 * i));
    if (ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
  endfunction

  // Reference state update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lcnt  <= '0;
      m_scnt  <= '0;
      m_faddr <= '0;
      m_fstat <= '0;
    end else if (bus.mem_we || bus.mem_re) begin
      if (m_err(bus.addr, bus.mem_we, bus.mem_re, bus.mem_op)) begin
        if (!m_fstat[0]) begin
          m_fstat <= {!m_ram(bus.addr) && !m_mmio(bus.addr), bus.mem_we, bus.mem_op, 1'b1};
          m_faddr <= bus.addr;
        end
      end else if (m_ram(bus.addr)) begin
        if (bus.mem_we) begin
          for (int i = 0; i < m_size(bus.mem_op); i++)
            m_mem[bus.addr + 32'(i)] <= bus.wdata[8*i +: 8];
          m_scnt <= m_scnt + 32'd1;
        end else begin
          m_lcnt <= m_lcnt + 32'd1;
        end
      end else if (bus.mem_we && bus.addr == MB + 32'd12 && bus.wdata[0]) begin
        m_fstat <= '0;
        m_faddr <= '0;
      end
    end
  end

  // Continuous compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata", bus.rdata, m_read(bus.addr, bus.mem_we, bus.mem_re, bus.mem_op, bus.ext_op));
      chk("fault", {31'b0, bus.fault}, {31'b0, m_fstat[0]});
      chk("dbg_data", bus.dbg_data, m_word(int'(bus.dbg_sel)));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic re, input logic [1:0] op, input logic ext);
    bus.addr   = a;
    bus.wdata  = d;
    bus.mem_we = we;
    bus.mem_re = re;
    bus.mem_op = op;
    bus.ext_op = ext;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    drive(a, d, 1'b1, 1'b0, op, 1'b0);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] op,
                    input logic ext, input logic [31:0] exp);
    drive(a, 32'h0, 1'b0, 1'b1, op, ext);
    @(negedge clk);
    chk(nm, bus.rdata, exp);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    logic [31:0] a;
    int r;
    idle();
    bus.dbg_sel = '0;
    #1;
    chk("rst_fault", {31'b0, bus.fault}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ld("rst_lcnt",  MB,          2'b00, 1'b0, 32'h0);
    ld("rst_scnt",  MB + 32'h4,  2'b00, 1'b0, 32'h0);
    ld("rst_faddr", MB + 32'h8,  2'b00, 1'b0, 32'h0);
    ld("rst_fstat", MB + 32'hC,  2'b00, 1'b0, 32'h0);

    for (int w = 0; w < INIT_W; w++) st(32'(4 * w), 32'h0, 2'b00);
    chk_en = 1'b1;

    // Lane order and extension
    st(32'h10, 32'h1234_5678, 2'b00);
    ld("t1_b11", 32'h11, 2'b10, 1'b1, 32'h0000_0056);
    ld("t1_b13", 32'h13, 2'b10, 1'b0, 32'h0000_0012);
    ld("t1_h12", 32'h12, 2'b01, 1'b1, 32'h0000_1234);
    ld("t1_w10", 32'h10, 2'b00, 1'b0, 32'h1234_5678);

    // Partial store keeps other lanes
    st(32'h20, 32'h0, 2'b00);
    st(32'h20, 32'h80, 2'b10);
    ld("t2_bsx", 32'h20, 2'b10, 1'b1, 32'hFFFF_FF80);
    ld("t2_bzx", 32'h20, 2'b10, 1'b0, 32'h0000_0080);
    ld("t2_w",   32'h20, 2'b00, 1'b0, 32'h0000_0080);

    // Misaligned store, first fault wins, clear
    st(32'h22, 32'hDEAD_BEEF, 2'b00);
    bus.dbg_sel = 8;
    #1;
    chk("t3_ram", bus.dbg_data, 32'h0000_0080);
    chk("t3_fault", {31'b0, bus.fault}, 32'h1);
    ld("t3_faddr",  MB + 32'h8, 2'b00, 1'b0, 32'h22);
    ld("t3_fstat",  MB + 32'hC, 2'b00, 1'b0, 32'h9);
    ld("t3_h31",    32'h31,     2'b01, 1'b0, 32'h0);
    ld("t3_faddr2", MB + 32'h8, 2'b00, 1'b0, 32'h22);
    st(MB + 32'hC, 32'h1, 2'b00);
    chk("t3_clr", {31'b0, bus.fault}, 32'h0);
    ld("t3_faddr3", MB + 32'h8, 2'b00, 1'b0, 32'h0);

    // Counters from a clean reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    st(32'h50, 32'hA5A5_0001, 2'b00);
    st(32'h54, 32'hA5A5_0002, 2'b00);
    st(32'h58, 32'hA5A5_0003, 2'b00);
    ld("t4_l50",   32'h50,     2'b00, 1'b0, 32'hA5A5_0001);
    ld("t4_l54",   32'h54,     2'b00, 1'b0, 32'hA5A5_0002);
    ld("t4_mis",   32'h52,     2'b00, 1'b0, 32'h0);
    ld("t4_faddr", MB + 32'h8, 2'b00, 1'b0, 32'h52);
    ld("t4_lcnt",  MB,         2'b00, 1'b0, 32'h2);
    ld("t4_scnt",  MB + 32'h4, 2'b00, 1'b0, 32'h3);

    // Error classes
    st(MB + 32'hC, 32'h1, 2'b00);
    ld("t5_bmmio", MB, 2'b10, 1'b0, 32'h0);
    chk("t5_bmmio_fault", {31'b0, bus.fault}, 32'h1);
    st(MB + 32'hC, 32'h1, 2'b00);
    ld("t5_oor",   32'h9000,   2'b00, 1'b0, 32'h0);
    ld("t5_ostat", MB + 32'hC, 2'b00, 1'b0, 32'h11);
    st(MB + 32'hC, 32'h1, 2'b00);
    ld("t5_rsv",   32'h40,     2'b11, 1'b0, 32'h0);
    chk("t5_rsv_fault", {31'b0, bus.fault}, 32'h1);
    ld("t5_rstat", MB + 32'hC, 2'b00, 1'b0, 32'h7);

    // Asynchronous reset between edges, store on a reset edge dropped
    rst = 1'b1;
    #1;
    chk("t6_fault", {31'b0, bus.fault}, 32'h0);
    drive(MB, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    #1;
    chk("t6_lcnt", bus.rdata, 32'h0);
    drive(MB + 32'h4, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    #1;
    chk("t6_scnt", bus.rdata, 32'h0);
    drive(32'h10, 32'hAAAA_AAAA, 1'b1, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    bus.dbg_sel = 4;
    #1;
    chk("t6_ram", bus.dbg_data, 32'h1234_5678);
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = 32'($urandom_range(0, 255));
      else if (r < 8)  a = MB + 32'($urandom_range(0, 15));
      else if (r == 8) a = 32'($urandom_range(32'h1000, 32'h7EFF));
      else             a = 32'($urandom_range(32'h7F10, 32'hFFFF_FFFF));
      if (it % 20 == 19)
        drive(MB + 32'hC, 32'h1, 1'b1, 1'b0, 2'b00, 1'b0);
      else
        drive(a, $urandom, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      bus.dbg_sel = 10'($urandom_range(0, INIT_W - 1));
      @(posedge clk);
      #1;
    end
    idle();
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder on the far end of the single-cycle CPU's data port. It serves word, halfword and byte loads and stores selected by the CPU's memOp and EXTOp signals. It detects misaligned, reserved-op and out-of-range accesses, keeps load/store counters, and exposes a small memory-mapped status window. Reads are combinational so the CPU completes a load in its single cycle. Writes and all state updates happen on the clock edge.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words; byte range 0 .. DEPTH_WORDS*4-1; DEPTH_WORDS*4 must be <= MMIO_BASE.
MMIO_BASE, 32'h0000_7F00, base of the 16-byte status window.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
addr  in  32  byte address (CPU aluout).
wdata  in  32  store data (CPU writedata).
mem_we  in  1  store request (CPU MemWrite).
mem_re  in  1  load request (top-level decode of WDSel==01).
mem_op  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
ext_op  in  1  load extension: 1 sign-extend, 0 zero-extend.
rdata  out  32  load data (CPU readdata), combinational.
fault  out  1  sticky fault flag, registered.
dbg_sel  in  $clog2(DEPTH_WORDS)  debug word index.
dbg_data  out  32  RAM word at dbg_sel, combinational.

Behaviour:
- Reset (asynchronous, active-high): load_cnt=0, store_cnt=0, fault_addr=0, fault_stat=0, so fault=0 immediately. RAM contents are not reset.
- Byte order is little-endian. Lane addr[1:0]=0 maps to bits 7:0.
- Region decode:
  - RAM: addr < DEPTH_WORDS*4.
  - MMIO: MMIO_BASE <= addr < MMIO_BASE+16.
  - Anything else is out-of-range.
- Alignment: a word access requires addr[1:0]=0; a halfword access requires addr[0]=0. A byte access is always aligned.
- Access validity: an access is active when mem_we|mem_re. If both are high, it is treated as a store only.
- Error: an active access is in error if it is misaligned, uses mem_op=11, or is out-of-range.
- Load path (combinational, zero latency):
  - RAM word: rdata = mem[addr>>2].
  - Halfword: select the half addr[1]. Byte: select the lane addr[1:0]. Then sign- or zero-extend per ext_op.
  - Errored load: rdata=0.
  - When mem_re=0: rdata=0.
- Store path (on posedge clk, aligned RAM only):
  - Word: write all 4 lanes.
  - Halfword: write wdata[15:0] into half addr[1].
  - Byte: write wdata[7:0] into lane addr[1:0].
  - Other lanes are unchanged.
  - Errored stores are dropped with no RAM change.
- MMIO window (word access only; halfword/byte to MMIO = error):
  - +0x0 load_cnt, read-only.
  - +0x4 store_cnt, read-only.
  - +0x8 fault_addr, read-only.
  - +0xC fault_stat:
    - bit0 sticky fault.
    - bits2:1 mem_op of the faulting access.
    - bit3 faulting access was a store.
    - bit4 out-of-range.
    - Writing 1 to bit0 clears the whole register and fault_addr. Other bits are ignored on write.
  - Writes to +0x0..+0x8 are ignored, not an error.
- Counters (posedge clk): load_cnt or store_cnt increments by 1 for each non-errored RAM access of that kind. MMIO accesses and errored accesses are not counted. Counters wrap 0xFFFF_FFFF -> 0.
- Fault capture (posedge clk):
  - On an errored access while bit0=0: set bit0, record op/store/range bits, fault_addr=addr.
  - While bit0=1: further errors change nothing (first fault wins).
  - fault = fault_stat[0].
- Hold: with mem_we=mem_re=0, no state changes.
- Reset mid-operation: a store whose edge coincides with rst asserted is dropped. Counters and fault state return to 0 without waiting for a clock edge.

Decomposition:
- Package dmem_pkg holds:
  - mem_op encodings (MOP_W/MOP_H/MOP_B/MOP_RSV).
  - MMIO offsets (OFF_LCNT/OFF_SCNT/OFF_FADDR/OFF_FSTAT).
  - fault_stat bit positions.
- Sub-module dmem_align is combinational and holds:
  - alignment check.
  - load lane select plus extension.
  - store byte-enable and lane-shifted write data.
- dmem_resp holds the RAM array, decode, counters and fault registers.

Test Plan:
1. Store word 0x12345678 at 0x10, then load from 0x10:
   - byte at 0x11, ext=1 -> 0x00000056.
   - byte at 0x13 -> 0x00000012.
   - halfword at 0x12, ext=1 -> 0x00001234.
   - word -> 0x12345678.
2. Store word 0 at 0x20, then byte 0x80 at 0x20:
   - byte load, ext=1 -> 0xFFFFFF80; ext=0 -> 0x00000080.
   - word load -> 0x00000080 (other lanes intact).
3. Word store 0xDEADBEEF at 0x22:
   - RAM unchanged (dbg_data), fault=1 after the edge.
   - 0x7F08 reads 0x22; 0x7F0C reads 0x9 (bit0 set, op=00, store).
   - Then halfword load at 0x31: fault_addr still 0x22.
   - Word store 1 to 0x7F0C: fault=0; 0x7F08 reads 0.
4. 3 stores and 2 loads to RAM, plus one misaligned load and one MMIO read:
   - 0x7F00 reads 2; 0x7F04 reads 3.
5. Accesses that must error:
   - Byte load from 0x7F00 -> rdata=0, fault=1.
   - Load at 0x9000 -> rdata=0, fault_stat bit4=1.
   - mem_op=11 at 0x40 -> rdata=0, fault=1.
6. Pulse rst between clock edges after test 4:
   - fault=0 and counters read 0 without waiting for an edge.
   - RAM word at 0x10 still 0x12345678.
   - Store pending on the edge during reset is not written.
